// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit that owns the HI/LO registers.
// The 64-bit result is computed combinationally when Start is accepted and held
// in a pending register. Only the write to HI/LO is delayed by the cycle count.
//
// State table:
//   state | meaning
//   IDLE  | Busy=0; accepts mult/multu/div/divu/mthi/mtlo on Start
//   RUN   | Busy=1; cnt counts down, pending result is committed when cnt==1
//
// Ports:
//   clk       in   1  system clock, rising edge
//   reset     in   1  synchronous active-high reset
//   Start     in   1  MDOp/operands valid this cycle
//   MDOp      in   3  000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                     101 mthi, 110 mtlo, 111 reserved (none)
//   Operand1  in  32  rs: multiplicand/dividend, source for mthi/mtlo
//   Operand2  in  32  rt: multiplier/divisor
//   Busy      out  1  operation in progress
//   Hi        out 32  HI register
//   Lo        out 32  LO register
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] Operand1,
  input  logic [31:0] Operand2,
  output logic        Busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

  logic [0:0]  state;
  logic [4:0]  cnt;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        p_skip;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_zero;
  logic [31:0] divisor;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  assign prod_s = $signed({{32{Operand1[31]}}, Operand1}) *
                  $signed({{32{Operand2[31]}}, Operand2});
  assign prod_u = {32'b0, Operand1} * {32'b0, Operand2};

  // A zero divisor is replaced by 1 so the dividers never see X; the result is
  // discarded anyway through p_skip.
  assign div_zero = (Operand2 == 32'b0);
  assign divisor  = div_zero ? 32'd1 : Operand2;

  // Signed divide through magnitudes: 0x80000000 has magnitude 0x80000000 as an
  // unsigned value, so 0x80000000 / -1 naturally yields quotient 0x80000000.
  assign a_mag = Operand1[31] ? (32'b0 - Operand1) : Operand1;
  assign b_mag = divisor[31]  ? (32'b0 - divisor)  : divisor;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (Operand1[31] ^ divisor[31]) ? (32'b0 - q_mag) : q_mag;
  assign r_s   = Operand1[31] ? (32'b0 - r_mag) : r_mag;

  assign q_u = Operand1 / divisor;
  assign r_u = Operand1 % divisor;

  assign Busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      p_hi   <= 32'b0;
      p_lo   <= 32'b0;
      p_skip <= 1'b0;
      Hi     <= 32'b0;
      Lo     <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            case (MDOp)
              OP_MULT: begin
                {p_hi, p_lo} <= prod_s;
                p_skip <= 1'b0;
                cnt    <= MULT_CNT;
                state  <= RUN;
              end
              OP_MULTU: begin
                {p_hi, p_lo} <= prod_u;
                p_skip <= 1'b0;
                cnt    <= MULT_CNT;
                state  <= RUN;
              end
              OP_DIV: begin
                p_hi   <= r_s;
                p_lo   <= q_s;
                p_skip <= div_zero;
                cnt    <= DIV_CNT;
                state  <= RUN;
              end
              OP_DIVU: begin
                p_hi   <= r_u;
                p_lo   <= q_u;
                p_skip <= div_zero;
                cnt    <= DIV_CNT;
                state  <= RUN;
              end
              OP_MTHI: Hi <= Operand1;
              OP_MTLO: Lo <= Operand1;
              default: ;
            endcase
          end
        end
        default: begin
          // Start is ignored while running; the hazard unit should prevent it.
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            if (!p_skip) begin
              Hi <= p_hi;
              Lo <= p_lo;
            end
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic        Busy;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Busy(Busy), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int exp_busy);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    exp_busy = 0;
    case (op)
      3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; exp_busy = MC; end
      3'd2: begin p = ua * ub; m_hi = p[63:32]; m_lo = p[31:0]; exp_busy = MC; end
      3'd3: begin
        exp_busy = DC;
        if (b != 0) begin
          p = 64'(sa / sb); m_lo = p[31:0];
          p = 64'(sa % sb); m_hi = p[31:0];
        end
      end
      3'd4: begin
        exp_busy = DC;
        if (b != 0) begin
          p = ua / ub; m_lo = p[31:0];
          p = ua % ub; m_hi = p[31:0];
        end
      end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    int exp_n;
    model(op, a, b, exp_n);
    Start = 1'b1; MDOp = op; Operand1 = a; Operand2 = b;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0; Operand1 = $urandom; Operand2 = $urandom;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), 32'(exp_n));
    check("hi", Hi, m_hi);
    check("lo", Lo, m_lo);
  endtask

  initial begin
    int n;
    logic [2:0]  op;
    logic [31:0] a, b;

    reset = 1'b1; Start = 1'b1; MDOp = 3'd1; Operand1 = 32'd9; Operand2 = 32'd9;
    m_hi = 32'b0; m_lo = 32'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; Start = 1'b0; MDOp = 3'd0;
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_hi", Hi, 32'd0);
    check("rst_lo", Lo, 32'd0);
    @(negedge clk);
    check("rst_busy_after", {31'b0, Busy}, 32'd0);

    run_op(3'd1, 32'hFFFFFFFE, 32'd3);
    check("mult_hi_const", Hi, 32'hFFFFFFFF);
    check("mult_lo_const", Lo, 32'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFFE, 32'd3);
    check("multu_hi_const", Hi, 32'h00000002);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2);
    check("div_lo_const", Lo, 32'hFFFFFFFD);
    check("div_hi_const", Hi, 32'hFFFFFFFF);
    run_op(3'd4, 32'd7, 32'd2);
    check("divu_lo_const", Lo, 32'd3);
    check("divu_hi_const", Hi, 32'd1);

    run_op(3'd5, 32'h11111111, 32'd0);
    run_op(3'd6, 32'h22222222, 32'd0);
    run_op(3'd4, 32'd55, 32'd0);
    check("div0_hi_const", Hi, 32'h11111111);
    check("div0_lo_const", Lo, 32'h22222222);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    check("ovf_lo_const", Lo, 32'h80000000);
    check("ovf_hi_const", Hi, 32'h00000000);

    // Start while running must be ignored entirely.
    model(3'd1, 32'd6, 32'd7, n);
    Start = 1'b1; MDOp = 3'd1; Operand1 = 32'd6; Operand2 = 32'd7;
    @(negedge clk);
    n = 0;
    for (int k = 0; k < 3; k++) begin
      if (Busy) n++;
      case (k)
        0: begin Start = 1'b1; MDOp = 3'd5; Operand1 = 32'hDEADBEEF; end
        1: begin Start = 1'b1; MDOp = 3'd3; Operand1 = 32'd100; Operand2 = 32'd3; end
        default: begin Start = 1'b0; MDOp = 3'd0; end
      endcase
      @(negedge clk);
    end
    while (Busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("ignore_busy_cycles", 32'(n), 32'(MC));
    check("ignore_hi", Hi, 32'd0);
    check("ignore_lo", Lo, 32'd42);
    @(negedge clk);
    check("ignore_no_restart", {31'b0, Busy}, 32'd0);

    // Reset on the 4th busy cycle cancels the divide.
    Start = 1'b1; MDOp = 3'd4; Operand1 = 32'd100; Operand2 = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDOp = 3'd0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    check("pre_reset_busy", {31'b0, Busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'b0; m_lo = 32'b0;
    check("midrst_busy", {31'b0, Busy}, 32'd0);
    check("midrst_hi", Hi, 32'd0);
    check("midrst_lo", Lo, 32'd0);
    run_op(3'd1, 32'd2, 32'd3);
    check("post_rst_lo", Lo, 32'd6);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: begin a = 32'h80000000 | 32'($urandom_range(0, 99)); b = 32'hFFFFFFF0 | 32'($urandom_range(0, 15)); end
        default: ;
      endcase
      run_op(op, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
